sm83_nand_dffr_spare_bank: RTL

//  Parametrised ECO spare cluster for the SM83 core netlist.
//  - WIDTH channels; each channel is one FAN_IN-input NAND feeding one

---
 rtl/sm83_nand_dffr_spare_bank_pkg.sv | 12 +
 rtl/sm83_timing.sv | 23 ++
 rtl/sm83_dffr_spare.sv | 58 +++++
 rtl/sm83_nand_dffr_spare_bank.sv | 57 +++++
 4 files changed

// File: rtl/sm83_nand_dffr_spare_bank_pkg.sv
// Local types and limits for the SM83 NAND/flop ECO spare bank.
package sm83_nand_dffr_spare_bank_pkg;
    localparam int FAN_IN_MIN = 2;
    localparam int FAN_IN_MAX = 4;

    typedef enum logic [1:0] {
        M_HOLD  = 2'd0,
        M_LOAD  = 2'd1,
        M_SHIFT = 2'd2,
        M_BAD   = 2'd3
    } spare_mode_e;
endpackage

// File: rtl/sm83_timing.sv
// Shared SM83 timing model: unit sizes, device resistances and Elmore delay helpers.
// Delays come out in the same units as the load arguments passed in.
package sm83_timing;
    localparam real L_unit       = 1.0;
    localparam real W_spare_unit = 5.0;

    function automatic real R_pmos_ohm(input real w);
        return 25000.0 / w;
    endfunction

    function automatic real R_nmos_ohm(input real w);
        return 12500.0 / w;
    endfunction

    function automatic real tpd_elmore(input real load, input real r_drv);
        return 0.69 * r_drv * load;
    endfunction

    // The NAND pull-down is a series stack, so its resistance scales with fan-in.
    function automatic real tpd_nand_fall(input real load, input int fan_in);
        return tpd_elmore(load, R_nmos_ohm(W_spare_unit * L_unit) * real'(fan_in));
    endfunction
endpackage

// File: rtl/sm83_dffr_spare.sv
// Single-bit spare flop: async active-low reset, enable, parallel/serial input select.
// An unknown enable or select poisons the state instead of silently holding.
module sm83_dffr_spare
    import sm83_timing::*;
    import sm83_nand_dffr_spare_bank_pkg::*;
#(
    parameter real L_q = 0.0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_shift,
    input  logic i_d,
    input  logic i_sd,
    output logic o_q
);
    spare_mode_e w_mode;
    logic        r_q;

    if (L_q < 0.0) begin : g_bad_param
        $error("sm83_dffr_spare: L_q must be non-negative");
    end

    // X on en/shift falls through every compare into M_BAD.
    always_comb begin
        w_mode = M_BAD;
        if (i_en == 1'b0)
            w_mode = M_HOLD;
        else if (i_en == 1'b1) begin
            if (i_shift == 1'b1)
                w_mode = M_SHIFT;
            else if (i_shift == 1'b0)
                w_mode = M_LOAD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= 1'b0;
        else begin
            case (w_mode)
                M_HOLD:  r_q <= r_q;
                M_LOAD:  r_q <= i_d;
                M_SHIFT: r_q <= i_sd;
                default: r_q <= 1'bx;
            endcase
        end
    end

    assign o_q = r_q;

    specify
        specparam T_QR = tpd_elmore(L_q, R_pmos_ohm(W_spare_unit * L_unit));
        specparam T_QF = tpd_elmore(L_q, R_nmos_ohm(W_spare_unit * L_unit));
        (i_clk   => o_q) = (T_QR, T_QF);
        (i_rst_n => o_q) = (T_QR, T_QF);
    endspecify
endmodule

// File: rtl/sm83_nand_dffr_spare_bank.sv
// ECO spare cluster: WIDTH channels of FAN_IN-input NAND feeding a resettable flop.
// Flops either capture their NAND in parallel or form a shift chain sin -> q[0] -> ... -> sout.
module sm83_nand_dffr_spare_bank
    import sm83_timing::*;
    import sm83_nand_dffr_spare_bank_pkg::*;
#(
    parameter int  WIDTH  = 4,
    parameter int  FAN_IN = 2,
    parameter real L_y    = 0.0,
    parameter real L_q    = 0.0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WIDTH*FAN_IN-1:0] in,
    input  logic                    en,
    input  logic                    shift,
    input  logic                    sin,
    output logic [WIDTH-1:0]        y,
    output logic [WIDTH-1:0]        q,
    output logic                    sout
);
    logic [WIDTH-1:0] w_sd;

    if (WIDTH < 1 || FAN_IN < FAN_IN_MIN || FAN_IN > FAN_IN_MAX || L_y < 0.0 || L_q < 0.0)
    begin : g_bad_param
        $error("sm83_nand_dffr_spare_bank: parameter out of range");
    end

    // Serial data for each flop: sin into channel 0, otherwise the lower neighbour.
    if (WIDTH == 1) begin : g_sd_1
        assign w_sd = sin;
    end else begin : g_sd_n
        assign w_sd = {q[WIDTH-2:0], sin};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        assign y[i] = ~(&in[i*FAN_IN +: FAN_IN]);

        sm83_dffr_spare #(.L_q(L_q)) u_ff (
            .i_clk   (clk),
            .i_rst_n (reset_n),
            .i_en    (en),
            .i_shift (shift),
            .i_d     (y[i]),
            .i_sd    (w_sd[i]),
            .o_q     (q[i])
        );
    end

    assign sout = q[WIDTH-1];

    specify
        specparam T_YR = tpd_elmore(L_y, R_pmos_ohm(W_spare_unit * L_unit));
        specparam T_YF = tpd_nand_fall(L_y, FAN_IN);
        (in *> y) = (T_YR, T_YF);
    endspecify
endmodule
